// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Included by the PC register and the fetch_unit top.
package fetch_unit_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam int CNT_W  = 32;

    localparam logic [ADDR_W-1:0] PC_INC       = 64'd4;
    localparam logic [INST_W-1:0] NOP_INST_ENC = 32'hD503201F;
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_REDIRECT,
        ACT_HOLD,
        ACT_ADVANCE
    } fetch_act_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } if_id_t;

    // Reset beats redirect, redirect beats stall.
    function automatic fetch_act_e fetch_act(
        input logic rst,
        input logic br,
        input logic stall
    );
        if (rst)
            return ACT_RESET;
        else if (br)
            return ACT_REDIRECT;
        else if (stall)
            return ACT_HOLD;
        else
            return ACT_ADVANCE;
    endfunction

    function automatic logic [ADDR_W-1:0] align_pc(
        input logic [ADDR_W-1:0] a
    );
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c
    );
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter: synchronous reset to an aligned RESET_PC,
// load on request, otherwise hold.
module pc_register
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst)
            pc <= align_pc(RESET_PC);
        else if (load)
            pc <= next_pc;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline
// register and a saturating count of fetched instructions.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 64'h0,
    parameter logic [INST_W-1:0] NOP_INST    = NOP_INST_ENC,
    parameter logic [CNT_W-1:0]  COUNT_RESET = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic [INST_W-1:0] IMData,
    output logic [ADDR_W-1:0] IMAddr,
    output logic [ADDR_W-1:0] IFID_PC,
    output logic [INST_W-1:0] IFID_Inst,
    output logic              IFID_Valid,
    output logic [CNT_W-1:0]  FetchCount
);

    fetch_act_e        act;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_load;
    if_id_t            ifid_q;
    if_id_t            bubble;
    logic [CNT_W-1:0]  count_q;

    assign act    = fetch_act(Reset, BranchTaken, Stall);
    assign bubble = '{pc: '0, inst: NOP_INST, valid: 1'b0};

    always_comb begin
        pc_load = 1'b0;
        pc_next = pc + PC_INC;
        unique case (act)
            ACT_REDIRECT: begin
                pc_load = 1'b1;
                pc_next = align_pc(BranchTarget);
            end
            ACT_ADVANCE: pc_load = 1'b1;
            default: ;
        endcase
    end

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (Clock),
        .rst     (Reset),
        .load    (pc_load),
        .next_pc (pc_next),
        .pc      (pc)
    );

    always_ff @(posedge Clock) begin
        unique case (act)
            ACT_RESET: begin
                ifid_q  <= bubble;
                count_q <= COUNT_RESET;
            end
            ACT_REDIRECT: ifid_q <= bubble;
            ACT_ADVANCE: begin
                ifid_q  <= '{pc: pc, inst: IMData, valid: 1'b1};
                count_q <= sat_inc(count_q);
            end
            default: ;
        endcase
    end

    assign IMAddr     = pc;
    assign IFID_PC    = ifid_q.pc;
    assign IFID_Inst  = ifid_q.inst;
    assign IFID_Valid = ifid_q.valid;
    assign FetchCount = count_q;

endmodule
